// File: rtl/ars_gf233_pkg.sv
// ars_gf233_pkg
//   Shared definitions for the GF(2^233) multiplier slice:
//   field degree, reduction taps of f(x) = x^233 + x^74 + 1,
//   the field element type and the sequencer state encoding.
package ars_gf233_pkg;

  localparam int M        = 233;
  localparam int F_TAP_HI = 74;
  localparam int F_TAP_LO = 0;

  typedef logic [M-1:0] gf233_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE_ST = 2'd2
  } state_t;

endpackage

// File: rtl/ars_gf_mulxd.sv
// ars_gf_mulxd
//   Combinational multiply by x^D modulo f(x) = x^233 + x^74 + 1.
//   The D bits shifted out of the top are folded back through taps 74 and 0.
//   One fold is enough because D <= 8 keeps 74 + D below 233.
// Ports
//   a : field element in
//   y : a * x^D mod f
module ars_gf_mulxd
  import ars_gf233_pkg::*;
#(
  parameter int D = 1
) (
  input  gf233_t a,
  output gf233_t y
);

  logic [D-1:0] ovf;
  gf233_t       shifted;
  gf233_t       fold;

  assign ovf     = a[M-1 -: D];
  assign shifted = a << D;
  assign fold    = (gf233_t'(ovf) << F_TAP_HI) ^ (gf233_t'(ovf) << F_TAP_LO);
  assign y       = shifted ^ fold;

endmodule

// File: rtl/ars_gfmul_ctrl.sv
// ars_gfmul_ctrl
//   Digit-serial MSB-first GF(2^233) multiplier with its sequencer.
//   Consumes D bits of B per cycle over K = ceil(233/D) iterations.
//   Optional feature macro: ARS_GFMUL_ABORT_EN (adds the abort input).
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request, sampled in IDLE and DONE_ST only
//   din_a  : operand A, latched on the accepting edge
//   din_b  : operand B, latched on the accepting edge
//   busy   : high while running
//   done   : one-cycle pulse, dout valid from this cycle
//   dout   : A*B mod f, held until the next accepted start
//   abort  : (ARS_GFMUL_ABORT_EN only) cancel a running multiply
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | one digit iteration per edge, cnt counts 0..K-1
// DONE_ST | result published, done high; start here is accepted directly
module ars_gfmul_ctrl
  import ars_gf233_pkg::*;
#(
  parameter int D = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   start,
  input  gf233_t din_a,
  input  gf233_t din_b,
  output logic   busy,
  output logic   done,
  output gf233_t dout
`ifdef ARS_GFMUL_ABORT_EN
  ,
  input  logic   abort
`endif
);

  localparam int K  = (M + D - 1) / D;
  localparam int KD = K * D;
  localparam int CW = $clog2(K + 1);

  state_t          state;
  gf233_t          a_q;
  gf233_t          acc;
  logic [KD-1:0]   b_q;
  logic [CW-1:0]   cnt;
  logic [D-1:0]    digit;
  gf233_t          acc_x;
  gf233_t          pp;
  gf233_t          acc_next;
  logic            abort_req;

`ifdef ARS_GFMUL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign digit = b_q[KD-1 -: D];

  ars_gf_mulxd #(.D(D)) u_acc_mulx (
    .a (acc),
    .y (acc_x)
  );

  // Partial product A*digit by Horner, MSB of the digit first:
  // h <- h*x ^ (bit ? A : 0), one x-multiply stage per digit bit.
  for (genvar i = 0; i < D; i++) begin : g_horner
    gf233_t hin;
    gf233_t hx;
    gf233_t hout;
    if (i == 0) begin : g_first
      assign hin = '0;
    end else begin : g_next
      assign hin = g_horner[i-1].hout;
    end
    ars_gf_mulxd #(.D(1)) u_pp_mulx (
      .a (hin),
      .y (hx)
    );
    assign hout = hx ^ (digit[D-1-i] ? a_q : '0);
  end

  assign pp       = g_horner[D-1].hout;
  assign acc_next = acc_x ^ pp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      dout  <= '0;
      acc   <= '0;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (abort_req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= acc_next;
            b_q <= b_q << D;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(K - 1)) begin
              dout  <= acc_next;
              state <= DONE_ST;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          done <= 1'b0;
          // In DONE_ST an abort beats a simultaneous start.
          if (start && !(state == DONE_ST && abort_req)) begin
            a_q   <= din_a;
            b_q   <= KD'(din_b);
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
